burst_ram: RTL and testbench
============================

# burst_ram

Burst-oriented RAM responder implementing the memory side of the `br_` interface driven by the cache arbiter. It accepts read/write burst commands, returns read bursts after a fixed latency, and applies byte-masked write bursts. It stands in for the external DDR/PSRAM controller in simulation and on-chip BRAM builds, and sits directly below the cache on the `br_` wires.

## Interface
- `DEPTH_BITWIDTH`, 4: address width in burst-data words; memory holds 2^DEPTH_BITWIDTH words
- `DATA_BITWIDTH`, 64: width of one burst-data word
- `BURST_DATA_COUNT`, 4: words per burst; must be >= 2
- `CYCLES_BEFORE_DATA_VALID`, 6: read latency L in cycles, >= 1
- `CYCLES_BEFORE_INITIATED`, 10: post-reset busy period I, >= 1
- `DATA_FILE`, "": optional hex file loaded at elaboration; empty means no initialisation
- `clk` in 1: clock
- `rst_n` in 1: reset, synchronous, active-low
- `cmd` in 1: 0 = read, 1 = write
- `cmd_en` in 1: command strobe, sampled only when `busy` is low
- `addr` in DEPTH_BITWIDTH: first word index of the burst
- `wr_data` in DATA_BITWIDTH: write word, one per cycle during a write burst
- `data_mask` in DATA_BITWIDTH/8: per-byte mask; bit = 1 means byte NOT written
- `rd_data` out DATA_BITWIDTH: read word
- `rd_data_valid` out 1: `rd_data` holds a valid burst word this cycle
- `busy` out 1: responder not accepting commands

## Operation
- States: INIT, IDLE, READ_DELAY, READ, WRITE.
- Reset (`rst_n` low at a clock edge): state INIT, `busy`=1, `rd_data_valid`=0, `rd_data`=0, counters cleared. Memory array not cleared. Reset mid-burst aborts it; words already written stay written; no further valid words emitted.
- INIT: count I cycles, then IDLE with `busy`=0.
- IDLE: on `cmd_en`=1 latch `cmd`, `addr`. Read -> READ_DELAY. Write -> word 0 written this same cycle from `wr_data`/`data_mask` at `addr`, then WRITE.
- READ_DELAY: L-1 cycles; memory read issued so first word is presented exactly L cycles after the command.
- READ: BURST_DATA_COUNT consecutive cycles of `rd_data_valid`=1, words `addr`, `addr`+1, ...; then IDLE.
- WRITE: BURST_DATA_COUNT-1 cycles, one word written per cycle from current `wr_data`/`data_mask`; then IDLE.
- Word index i of a burst is (`addr` + i) mod 2^DEPTH_BITWIDTH; wrap across top of memory is legal.
- `cmd_en` while `busy`=1 is ignored (no queueing, no error).
- `rd_data` holds its last value when `rd_data_valid`=0.
- Write with all mask bits 1 leaves memory unchanged but still runs the full burst timing.

## Timing
- Command accepted at edge T (IDLE, `cmd_en`=1).
- `busy` rises at T+1 for both commands (the cache requires one cycle for busy to go high).
- Read: `rd_data_valid`=1 during cycles T+L .. T+L+BURST_DATA_COUNT-1; `busy`=0 from T+L+BURST_DATA_COUNT. Default: valid T+6..T+9, idle at T+10.
- Write: words sampled at T .. T+BURST_DATA_COUNT-1; `busy`=0 from T+BURST_DATA_COUNT. Default: idle at T+4.
- Back-to-back: new `cmd_en` accepted in the first cycle `busy` is 0.
- After reset release: `busy`=1 for exactly I cycles.
- Read of a word in the cycle after its write completes returns the new value (no stale read).

## Structure
- Shared package: `CMD_READ`=0, `CMD_WRITE`=1, state encodings (one-hot, 5 bits).
- One sub-module is natural: `burst_ram_array`, a single-port, byte-write-enable synchronous RAM (1-cycle read, write-mask inverted to byte enables, `DATA_FILE` load). The top module holds the FSM, latency/beat counters and address increment.

## Test plan
- Reset: hold `rst_n`=0 three cycles, release -> `busy`=1 for 10 cycles, then 0; `rd_data_valid`=0 throughout.
- Write burst `addr`=2, words 0x11..11, 0x22..22, 0x33..33, 0x44..44, mask 0 -> `busy` high T+1..T+3; read `addr`=2 -> valid T+6..T+9 with the same four words in order.
- Masked write `addr`=0, mask 0x0F on word 0, data 0xAAAA_AAAA_BBBB_BBBB over 0x1111_1111_2222_2222 -> read back 0xAAAA_AAAA_2222_2222.
- Wrap: write 4 words at `addr`=14 -> stored at 14, 15, 0, 1; read `addr`=14 returns them in that order.
- `cmd_en` pulsed at T+3 during a read -> ignored; only one 4-word valid burst; command at T+10 accepted.
- Reset asserted at T+7 of a read -> `rd_data_valid` 0 from next edge, `busy`=1 for 10 cycles; prior memory contents intact on subsequent read.

Source files
------------

// File: rtl/burst_ram_pkg.sv
// Shared definitions for the burst RAM responder: command codes,
// one-hot FSM state encodings and a small sizing helper.
package burst_ram_pkg;

  typedef enum logic {
    CMD_READ  = 1'b0,
    CMD_WRITE = 1'b1
  } cmd_t;

  typedef enum logic [4:0] {
    ST_INIT       = 5'b00001,
    ST_IDLE       = 5'b00010,
    ST_READ_DELAY = 5'b00100,
    ST_READ       = 5'b01000,
    ST_WRITE      = 5'b10000
  } state_t;

  // Largest of three values, used to size the shared cycle/beat counter.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/burst_ram_if.sv
// br_ bus between the cache arbiter (master) and the burst RAM (slave).
interface burst_ram_if #(
  parameter int DEPTH_BITWIDTH = 4,
  parameter int DATA_BITWIDTH  = 64
);

  burst_ram_pkg::cmd_t          cmd;
  logic                         cmd_en;
  logic [DEPTH_BITWIDTH-1:0]    addr;
  logic [DATA_BITWIDTH-1:0]     wr_data;
  logic [DATA_BITWIDTH/8-1:0]   data_mask;
  logic [DATA_BITWIDTH-1:0]     rd_data;
  logic                         rd_data_valid;
  logic                         busy;

  modport master (
    output cmd, cmd_en, addr, wr_data, data_mask,
    input  rd_data, rd_data_valid, busy
  );

  modport slave (
    input  cmd, cmd_en, addr, wr_data, data_mask,
    output rd_data, rd_data_valid, busy
  );

endinterface

// File: rtl/burst_ram_array.sv
// Single-port synchronous RAM with byte write enables and a one-cycle
// registered read port. The mask arrives in bus polarity (1 = keep byte)
// and is inverted here into byte enables. The read register only loads
// on rd_en, so it naturally holds the last word between bursts.
module burst_ram_array #(
  parameter int    ADDR_W    = 4,
  parameter int    DATA_W    = 64,
  parameter string DATA_FILE = ""
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rd_en,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [DATA_W/8-1:0] wr_mask,
  output logic [DATA_W-1:0] rd_data
);

  localparam int BYTES = DATA_W / 8;

  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic [BYTES-1:0]  byte_en;

  assign byte_en = wr_en ? ~wr_mask : '0;

  // Byte-granular write; the array itself is never cleared by reset.
  always_ff @(posedge clk) begin
    for (int b = 0; b < BYTES; b++) begin
      if (byte_en[b]) begin
        mem[addr][b*8 +: 8] <= wr_data[b*8 +: 8];
      end
    end
  end

  // Registered read word, cleared by reset and held when not reading.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[addr];
    end
  end

endmodule

// File: rtl/burst_ram.sv
// Burst RAM responder for the br_ bus. Holds the INIT/IDLE/READ_DELAY/
// READ/WRITE sequencer, a shared latency/beat counter and the running
// word pointer; storage lives in burst_ram_array.
//
// Timing (command accepted at edge T):
//   read  : memory reads issued at edges T+L-1 .. T+L+N-2, so rd_data is
//           valid in cycles T+L .. T+L+N-1 and busy drops for T+L+N.
//   write : words written at edges T .. T+N-1, busy drops for T+N.
module burst_ram
  import burst_ram_pkg::*;
#(
  parameter int    DEPTH_BITWIDTH           = 4,
  parameter int    DATA_BITWIDTH            = 64,
  parameter int    BURST_DATA_COUNT         = 4,
  parameter int    CYCLES_BEFORE_DATA_VALID = 6,
  parameter int    CYCLES_BEFORE_INITIATED  = 10,
  parameter string DATA_FILE                = ""
) (
  input  logic       clk,
  input  logic       rst_n,
  burst_ram_if.slave br
);

  localparam int CNT_MAX = max3(CYCLES_BEFORE_INITIATED, CYCLES_BEFORE_DATA_VALID,
                                BURST_DATA_COUNT);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] INIT_LAST  = CNT_W'(CYCLES_BEFORE_INITIATED - 1);
  localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(CYCLES_BEFORE_DATA_VALID - 1);
  localparam logic [CNT_W-1:0] BEAT_LAST  = CNT_W'(BURST_DATA_COUNT - 1);
  localparam logic [CNT_W-1:0] BEAT_COUNT = CNT_W'(BURST_DATA_COUNT);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [DEPTH_BITWIDTH-1:0] ADDR_ONE = DEPTH_BITWIDTH'(1);

  // With a one-cycle latency the first word is fetched straight from IDLE.
  localparam logic DIRECT_READ = (CYCLES_BEFORE_DATA_VALID == 1);

  state_t                    state;
  logic [CNT_W-1:0]          cnt;
  logic [DEPTH_BITWIDTH-1:0] cur_addr;
  logic                      busy_q;
  logic                      valid_q;

  logic                      accept_rd;
  logic                      accept_wr;
  logic                      issue_rd;
  logic                      mem_wr_en;
  logic [DEPTH_BITWIDTH-1:0] mem_addr;
  logic [DATA_BITWIDTH-1:0]  mem_rd_data;

  assign accept_rd = (state == ST_IDLE) && br.cmd_en && (br.cmd == CMD_READ);
  assign accept_wr = (state == ST_IDLE) && br.cmd_en && (br.cmd == CMD_WRITE);

  // Decide whether the RAM read port fires this cycle.
  always_comb begin
    issue_rd = 1'b0;
    unique case (state)
      ST_IDLE:       issue_rd = accept_rd && DIRECT_READ;
      ST_READ_DELAY: issue_rd = (cnt == DELAY_LAST);
      ST_READ:       issue_rd = (cnt != BEAT_COUNT);
      default:       issue_rd = 1'b0;
    endcase
  end

  // Writes are suppressed on a reset edge so an aborted burst stops cleanly.
  assign mem_wr_en = rst_n && (accept_wr || (state == ST_WRITE));
  assign mem_addr  = (state == ST_IDLE) ? br.addr : cur_addr;

  burst_ram_array #(
    .ADDR_W    (DEPTH_BITWIDTH),
    .DATA_W    (DATA_BITWIDTH),
    .DATA_FILE (DATA_FILE)
  ) u_array (
    .clk     (clk),
    .rst_n   (rst_n),
    .rd_en   (issue_rd),
    .wr_en   (mem_wr_en),
    .addr    (mem_addr),
    .wr_data (br.wr_data),
    .wr_mask (br.data_mask),
    .rd_data (mem_rd_data)
  );

  assign br.rd_data       = mem_rd_data;
  assign br.rd_data_valid = valid_q;
  assign br.busy          = busy_q;

  // Sequencer: init countdown, command acceptance, read latency and beats.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_INIT;
      cnt      <= '0;
      cur_addr <= '0;
      busy_q   <= 1'b1;
      valid_q  <= 1'b0;
    end else begin
      unique case (state)
        ST_INIT: begin
          if (cnt == INIT_LAST) begin
            state  <= ST_IDLE;
            busy_q <= 1'b0;
            cnt    <= '0;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end

        ST_IDLE: begin
          if (accept_wr) begin
            state    <= ST_WRITE;
            busy_q   <= 1'b1;
            cur_addr <= br.addr + ADDR_ONE;
            cnt      <= CNT_ONE;
          end else if (accept_rd) begin
            busy_q <= 1'b1;
            cnt    <= CNT_ONE;
            if (DIRECT_READ) begin
              state    <= ST_READ;
              valid_q  <= 1'b1;
              cur_addr <= br.addr + ADDR_ONE;
            end else begin
              state    <= ST_READ_DELAY;
              cur_addr <= br.addr;
            end
          end
        end

        ST_READ_DELAY: begin
          if (cnt == DELAY_LAST) begin
            state    <= ST_READ;
            valid_q  <= 1'b1;
            cur_addr <= cur_addr + ADDR_ONE;
            cnt      <= CNT_ONE;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end

        ST_READ: begin
          if (cnt == BEAT_COUNT) begin
            state   <= ST_IDLE;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            cnt     <= '0;
          end else begin
            cur_addr <= cur_addr + ADDR_ONE;
            cnt      <= cnt + CNT_ONE;
          end
        end

        ST_WRITE: begin
          if (cnt == BEAT_LAST) begin
            state  <= ST_IDLE;
            busy_q <= 1'b0;
            cnt    <= '0;
          end else begin
            cur_addr <= cur_addr + ADDR_ONE;
            cnt      <= cnt + CNT_ONE;
          end
        end

        default: begin
          state   <= ST_INIT;
          busy_q  <= 1'b1;
          valid_q <= 1'b0;
          cnt     <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_burst_ram.sv
// Scoreboard bench for burst_ram: expected read words are queued when a
// read is issued and compared by a monitor as valid beats appear.
module tb_burst_ram;
  import burst_ram_pkg::*;

  localparam int DEPTH = 4;
  localparam int DW    = 64;
  localparam int BURST = 4;
  localparam int LAT   = 6;
  localparam int INIT  = 10;

  logic clk;
  logic rst_n;

  int vectors;
  int miscompares;

  logic [DW-1:0] model [2**DEPTH];
  logic [DW-1:0] exp_q [$];

  logic [BURST-1:0][DW-1:0]   w;
  logic [BURST-1:0][DW/8-1:0] m;

  burst_ram_if #(.DEPTH_BITWIDTH(DEPTH), .DATA_BITWIDTH(DW)) br ();

  burst_ram #(
    .DEPTH_BITWIDTH           (DEPTH),
    .DATA_BITWIDTH            (DW),
    .BURST_DATA_COUNT         (BURST),
    .CYCLES_BEFORE_DATA_VALID (LAT),
    .CYCLES_BEFORE_INITIATED  (INIT),
    .DATA_FILE                ("")
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .br    (br)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [DW-1:0] got,
                             input logic [DW-1:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic void modelWrite(input logic [DEPTH-1:0] a, input logic [DW-1:0] d,
                                     input logic [DW/8-1:0] msk);
    for (int b = 0; b < DW/8; b++) begin
      if (!msk[b]) model[a][b*8 +: 8] = d[b*8 +: 8];
    end
  endfunction

  // Monitor: every valid beat must match the oldest queued word.
  always @(negedge clk) begin
    if (br.rd_data_valid) begin
      checkOutput("beat_expected", DW'(exp_q.size() != 0), DW'(1));
      if (exp_q.size() != 0) begin
        checkOutput("rd_word", br.rd_data, exp_q.pop_front());
      end
    end
  end

  // Starts at the negedge where rst_n is released (or reset is still showing).
  task automatic checkInitPeriod();
    for (int i = 0; i < INIT; i++) begin
      checkOutput("init_busy", DW'(br.busy), DW'(1));
      checkOutput("init_valid", DW'(br.rd_data_valid), DW'(0));
      @(negedge clk);
    end
    checkOutput("init_done_busy", DW'(br.busy), DW'(0));
  endtask

  // One burst command from a negedge; returns at the first idle negedge.
  task automatic applyStimulus(input cmd_t c, input logic [DEPTH-1:0] a,
                               input logic [BURST-1:0][DW-1:0] wd,
                               input logic [BURST-1:0][DW/8-1:0] wm,
                               input bit poke);
    checkOutput("busy_before_cmd", DW'(br.busy), DW'(0));
    br.cmd       = c;
    br.cmd_en    = 1'b1;
    br.addr      = a;
    br.wr_data   = wd[0];
    br.data_mask = wm[0];
    for (int i = 0; i < BURST; i++) begin
      if (c == CMD_WRITE) modelWrite(DEPTH'(a + i), wd[i], wm[i]);
      else exp_q.push_back(model[DEPTH'(a + i)]);
    end
    @(negedge clk);
    br.cmd_en = 1'b0;
    if (c == CMD_WRITE) begin
      for (int n = 1; n < BURST; n++) begin
        checkOutput("wr_busy", DW'(br.busy), DW'(1));
        checkOutput("wr_valid", DW'(br.rd_data_valid), DW'(0));
        br.wr_data   = wd[n];
        br.data_mask = wm[n];
        @(negedge clk);
      end
      br.data_mask = '1;
    end else begin
      for (int n = 1; n < LAT + BURST; n++) begin
        checkOutput("rd_busy", DW'(br.busy), DW'(1));
        checkOutput("rd_valid", DW'(br.rd_data_valid), DW'(n >= LAT));
        if (poke && n == 3) begin
          br.cmd       = CMD_WRITE;
          br.cmd_en    = 1'b1;
          br.addr      = a;
          br.wr_data   = 64'hDEAD_BEEF_DEAD_BEEF;
          br.data_mask = '0;
        end
        @(negedge clk);
        br.cmd_en    = 1'b0;
        br.data_mask = '1;
      end
    end
    checkOutput("busy_after", DW'(br.busy), DW'(0));
    checkOutput("valid_after", DW'(br.rd_data_valid), DW'(0));
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    for (int i = 0; i < 2**DEPTH; i++) model[i] = '0;
    rst_n        = 1'b0;
    br.cmd       = CMD_READ;
    br.cmd_en    = 1'b0;
    br.addr      = '0;
    br.wr_data   = '0;
    br.data_mask = '1;

    $display("[TB] reset and init period");
    repeat (3) @(negedge clk);
    checkOutput("reset_rd_data", br.rd_data, '0);
    rst_n = 1'b1;
    checkInitPeriod();

    $display("[TB] write then read at addr 2");
    w[0] = 64'h1111_1111_1111_1111; w[1] = 64'h2222_2222_2222_2222;
    w[2] = 64'h3333_3333_3333_3333; w[3] = 64'h4444_4444_4444_4444;
    m = '0;
    applyStimulus(CMD_WRITE, 4'd2, w, m, 1'b0);
    applyStimulus(CMD_READ, 4'd2, w, m, 1'b0);

    $display("[TB] masked write at addr 0");
    w[0] = 64'h1111_1111_2222_2222; w[1] = 64'h5555_5555_5555_5555;
    w[2] = 64'h6666_6666_6666_6666; w[3] = 64'h7777_7777_7777_7777;
    m = '0;
    applyStimulus(CMD_WRITE, 4'd0, w, m, 1'b0);
    w[0] = 64'hAAAA_AAAA_BBBB_BBBB; w[1] = 64'h0;
    w[2] = 64'h0;                   w[3] = 64'h0;
    m[0] = 8'h0F; m[1] = 8'hFF; m[2] = 8'hFF; m[3] = 8'hFF;
    applyStimulus(CMD_WRITE, 4'd0, w, m, 1'b0);
    applyStimulus(CMD_READ, 4'd0, w, m, 1'b0);

    $display("[TB] wrap across top of memory");
    w[0] = 64'hE0E0_E0E0_E0E0_E0E0; w[1] = 64'hF1F1_F1F1_F1F1_F1F1;
    w[2] = 64'h0A0A_0A0A_0A0A_0A0A; w[3] = 64'h1B1B_1B1B_1B1B_1B1B;
    m = '0;
    applyStimulus(CMD_WRITE, 4'd14, w, m, 1'b0);
    applyStimulus(CMD_READ, 4'd14, w, m, 1'b0);

    $display("[TB] command while busy is ignored, back-to-back accepted");
    applyStimulus(CMD_READ, 4'd2, w, m, 1'b1);
    applyStimulus(CMD_READ, 4'd2, w, m, 1'b0);

    $display("[TB] random write/read pairs");
    for (int k = 0; k < 4; k++) begin
      logic [DEPTH-1:0] ra;
      ra = DEPTH'($urandom_range(0, 2**DEPTH - 1));
      for (int i = 0; i < BURST; i++) begin
        w[i] = {$urandom, $urandom};
        m[i] = 8'($urandom);
      end
      applyStimulus(CMD_WRITE, ra, w, m, 1'b0);
      applyStimulus(CMD_READ, ra, w, m, 1'b0);
    end

    $display("[TB] reset during read burst");
    checkOutput("busy_before_abort", DW'(br.busy), DW'(0));
    br.cmd    = CMD_READ;
    br.cmd_en = 1'b1;
    br.addr   = 4'd14;
    for (int i = 0; i < BURST; i++) exp_q.push_back(model[DEPTH'(14 + i)]);
    @(negedge clk);
    br.cmd_en = 1'b0;
    for (int n = 1; n < 7; n++) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("abort_valid", DW'(br.rd_data_valid), DW'(0));
    checkOutput("abort_rd_data", br.rd_data, '0);
    checkOutput("abort_beats_left", DW'(exp_q.size()), DW'(2));
    exp_q.delete();
    rst_n = 1'b1;
    checkInitPeriod();
    applyStimulus(CMD_READ, 4'd14, w, m, 1'b0);
    applyStimulus(CMD_READ, 4'd2, w, m, 1'b0);

    repeat (2) @(negedge clk);
    checkOutput("leftover_beats", DW'(exp_q.size()), DW'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
